// File: rtl/exe_div_ctrl_if.sv
// EXE-stage divider bundle.
// The pipeline drives the request side; the divider returns stall, busy and the result.
interface exe_div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             es_valid;
  logic             div_req;
  logic             div_signed;
  logic             div_mod;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             es_fire;
  logic             flush;
  logic             div_stall;
  logic             div_busy;
  logic [WIDTH-1:0] div_result;

  modport master (
    output es_valid, div_req, div_signed, div_mod,
    output src1, src2, es_fire, flush,
    input  div_stall, div_busy, div_result
  );

  modport slave (
    input  es_valid, div_req, div_signed, div_mod,
    input  src1, src2, es_fire, flush,
    output div_stall, div_busy, div_result
  );
endinterface

// File: rtl/exe_div_ctrl.sv
// Iterative radix-2 restoring divider with EXE-stage stall control.
// Serves div.w, mod.w, div.wu and mod.wu; the result is held until the instruction leaves EXE.
module exe_div_ctrl #(
  parameter int WIDTH     = 32,
  parameter bit ZERO_FAST = 1'b1
) (
  input logic          clk,
  input logic          reset,
  exe_div_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] res;
  logic             q_neg;
  logic             r_neg;
  logic             mod_op;
  logic             dz;

  logic             start;
  logic             s1_neg;
  logic             s2_neg;
  logic             src2_zero;
  logic             last;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   upper;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo_fix;

  assign start     = bus.es_valid & bus.div_req & ~bus.flush;
  assign s1_neg    = bus.div_signed & bus.src1[WIDTH-1];
  assign s2_neg    = bus.div_signed & bus.src2[WIDTH-1];
  assign src2_zero = (bus.src2 == '0);
  assign a_abs     = s1_neg ? -bus.src1 : bus.src1;
  assign b_abs     = s2_neg ? -bus.src2 : bus.src2;

  // One restoring step: the partial remainder is always below the
  // divisor, so a successful difference fits back into WIDTH bits.
  assign upper  = {rem, quo[WIDTH-1]};
  assign ge     = (upper >= {1'b0, dvs});
  assign diff   = upper[WIDTH-1:0] - dvs;
  assign rem_nx = ge ? diff : upper[WIDTH-1:0];
  assign quo_nx = {quo[WIDTH-2:0], ge};
  assign last   = (cnt == LAST);

  // With a zero divisor every trial succeeds, leaving |src1| in rem;
  // the remainder sign fix then restores src1 bit-exactly.
  assign quo_fix = dz ? '1 : (q_neg ? -quo_nx : quo_nx);
  assign rem_fix = r_neg ? -rem_nx : rem_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      res    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      mod_op <= 1'b0;
      dz     <= 1'b0;
    end else if (bus.flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            rem    <= '0;
            cnt    <= '0;
            quo    <= a_abs;
            dvs    <= b_abs;
            q_neg  <= s1_neg ^ s2_neg;
            r_neg  <= s1_neg;
            mod_op <= bus.div_mod;
            dz     <= src2_zero;
            if (ZERO_FAST && src2_zero) begin
              state <= DONE;
              res   <= bus.div_mod ? bus.src1 : '1;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            res   <= mod_op ? rem_fix : quo_fix;
          end
        end
        DONE: begin
          if (bus.es_fire)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.div_stall  = ~bus.flush &
                          (((state == IDLE) & bus.es_valid & bus.div_req) |
                           (state == BUSY));
  assign bus.div_busy   = (state == BUSY);
  assign bus.div_result = res;

endmodule

// File: tb/tb_exe_div_ctrl.sv
// Directed bench for exe_div_ctrl: one instance with fast
// divide-by-zero (index 0) and one without (index 1).
module tb_exe_div_ctrl;

  logic clk;
  logic reset;

  logic        vld  [2];
  logic        req  [2];
  logic        sgn  [2];
  logic        mdq  [2];
  logic [31:0] a    [2];
  logic [31:0] b    [2];
  logic        fire [2];
  logic        fl   [2];
  logic        stall[2];
  logic        busy [2];
  logic [31:0] res  [2];

  int n_chk;
  int n_err;
  int cyc;
  logic [31:0] r;

  exe_div_ctrl_if #(.WIDTH(32)) if0 ();
  exe_div_ctrl_if #(.WIDTH(32)) if1 ();

  assign if0.es_valid   = vld[0];
  assign if0.div_req    = req[0];
  assign if0.div_signed = sgn[0];
  assign if0.div_mod    = mdq[0];
  assign if0.src1       = a[0];
  assign if0.src2       = b[0];
  assign if0.es_fire    = fire[0];
  assign if0.flush      = fl[0];
  assign stall[0]       = if0.div_stall;
  assign busy[0]        = if0.div_busy;
  assign res[0]         = if0.div_result;

  assign if1.es_valid   = vld[1];
  assign if1.div_req    = req[1];
  assign if1.div_signed = sgn[1];
  assign if1.div_mod    = mdq[1];
  assign if1.src1       = a[1];
  assign if1.src2       = b[1];
  assign if1.es_fire    = fire[1];
  assign if1.flush      = fl[1];
  assign stall[1]       = if1.div_stall;
  assign busy[1]        = if1.div_busy;
  assign res[1]         = if1.div_result;

  exe_div_ctrl #(.WIDTH(32), .ZERO_FAST(1'b1)) u_fast (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  exe_div_ctrl #(.WIDTH(32), .ZERO_FAST(1'b0)) u_slow (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called near a negedge; returns at the negedge after es_fire.
  task automatic run_div(input int s, input bit sg, input bit md,
                         input logic [31:0] x, input logic [31:0] y,
                         input int hold, output int n,
                         output logic [31:0] q);
    vld[s] = 1'b1;
    req[s] = 1'b1;
    sgn[s] = sg;
    mdq[s] = md;
    a[s]   = x;
    b[s]   = y;
    fire[s] = 1'b0;
    n = 0;
    #1;
    while (stall[s] === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    q = res[s];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      chk("hold_res", res[s], q);
      chk("hold_busy", 32'(busy[s]), 32'd0);
      chk("hold_stall", 32'(stall[s]), 32'd0);
    end
    fire[s] = 1'b1;
    @(negedge clk);
    vld[s]  = 1'b0;
    req[s]  = 1'b0;
    fire[s] = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 0; req[i] = 0; sgn[i] = 0; mdq[i] = 0;
      a[i] = '0; b[i] = '0; fire[i] = 0; fl[i] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_stall", 32'(stall[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_result", res[i], 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_div(0, 0, 0, 32'd100, 32'd7, 0, cyc, r);
    chk("divu_cyc", cyc, 33);
    chk("divu", r, 32'd14);
    run_div(0, 0, 1, 32'd100, 32'd7, 0, cyc, r);
    chk("modu_cyc", cyc, 33);
    chk("modu", r, 32'd2);

    run_div(0, 1, 0, 32'hFFFF_FF9C, 32'd7, 0, cyc, r);
    chk("div_neg", r, 32'hFFFF_FFF2);
    run_div(0, 1, 1, 32'hFFFF_FF9C, 32'd7, 0, cyc, r);
    chk("mod_neg", r, 32'hFFFF_FFFE);

    run_div(0, 0, 0, 32'h1234_5678, 32'd0, 0, cyc, r);
    chk("dz_fast_cyc", cyc, 1);
    chk("dz_fast_div", r, 32'hFFFF_FFFF);
    run_div(0, 0, 1, 32'h1234_5678, 32'd0, 0, cyc, r);
    chk("dz_fast_mod", r, 32'h1234_5678);
    run_div(1, 0, 0, 32'h1234_5678, 32'd0, 0, cyc, r);
    chk("dz_slow_cyc", cyc, 33);
    chk("dz_slow_div", r, 32'hFFFF_FFFF);
    run_div(1, 0, 1, 32'h1234_5678, 32'd0, 0, cyc, r);
    chk("dz_slow_mod", r, 32'h1234_5678);
    run_div(1, 1, 1, 32'h8765_4321, 32'd0, 0, cyc, r);
    chk("dz_slow_smod", r, 32'h8765_4321);
    run_div(0, 1, 0, 32'h8765_4321, 32'd0, 0, cyc, r);
    chk("dz_fast_sdiv", r, 32'hFFFF_FFFF);

    run_div(0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, cyc, r);
    chk("ovf_mod", r, 32'd0);
    run_div(0, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, cyc, r);
    chk("ovf_div", r, 32'h8000_0000);

    // Flush during the tenth BUSY cycle.
    vld[0] = 1; req[0] = 1; sgn[0] = 0; mdq[0] = 0;
    a[0] = 32'd100; b[0] = 32'd7;
    repeat (10) @(negedge clk);
    #1;
    chk("pre_flush_busy", 32'(busy[0]), 32'd1);
    fl[0] = 1'b1;
    #1;
    chk("flush_stall", 32'(stall[0]), 32'd0);
    @(negedge clk);
    fl[0] = 1'b0; vld[0] = 0; req[0] = 0;
    #1;
    chk("post_flush_busy", 32'(busy[0]), 32'd0);
    chk("post_flush_stall", 32'(stall[0]), 32'd0);
    chk("post_flush_res", res[0], 32'h8000_0000);
    run_div(0, 0, 0, 32'd9, 32'd3, 0, cyc, r);
    chk("after_flush_cyc", cyc, 33);
    chk("after_flush", r, 32'd3);

    run_div(0, 0, 0, 32'd1000, 32'd10, 5, cyc, r);
    chk("hold_div", r, 32'd100);
    run_div(0, 0, 0, 32'd50, 32'd5, 0, cyc, r);
    chk("b2b_cyc", cyc, 33);
    chk("b2b_div", r, 32'd10);

    // Reset in the middle of an operation.
    vld[1] = 1; req[1] = 1; sgn[1] = 0; mdq[1] = 0;
    a[1] = 32'd100; b[1] = 32'd7;
    repeat (5) @(negedge clk);
    #1;
    chk("mid_busy", 32'(busy[1]), 32'd1);
    reset = 1'b1;
    vld[1] = 0; req[1] = 0;
    @(negedge clk);
    #1;
    chk("mid_rst_busy", 32'(busy[1]), 32'd0);
    chk("mid_rst_stall", 32'(stall[1]), 32'd0);
    chk("mid_rst_res1", res[1], 32'd0);
    chk("mid_rst_res0", res[0], 32'd0);
    reset = 1'b0;
    @(negedge clk);
    run_div(1, 0, 0, 32'd9, 32'd3, 0, cyc, r);
    chk("after_rst_cyc", cyc, 33);
    chk("after_rst", r, 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/exe_div_ctrl.md
Name: exe_div_ctrl

Overview:
- Iterative radix-2 divider plus controller, instantiated in the EXE stage.
- Serves div.w, mod.w, div.wu and mod.wu; stalls EXE while the operation runs.
- Holds the result until the EXE instruction moves on to MEM.
- Cancels cleanly on a pipeline flush from exceptions or branches.

Parameters:
- WIDTH, 32, operand and result width.
- ZERO_FAST, 1, when 1 a divide by zero skips the iterations and goes straight to DONE.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- es_valid  input  1  EXE stage holds a valid instruction
- div_req  input  1  EXE instruction is a divide or modulo
- div_signed  input  1  1 = div.w/mod.w, 0 = div.wu/mod.wu
- div_mod  input  1  1 = return remainder, 0 = return quotient
- src1  input  WIDTH  dividend
- src2  input  WIDTH  divisor
- es_fire  input  1  EXE instruction leaves EXE this cycle
- flush  input  1  kill the in-flight EXE instruction
- div_stall  output  1  EXE must not advance; feeds es_ready_go
- div_busy  output  1  state is BUSY
- div_result  output  WIDTH  selected quotient or remainder, valid in DONE

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - State goes to IDLE and the counter to 0.
  - `div_stall` = 0, `div_busy` = 0, `div_result` = 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If `es_valid` & `div_req` & !`flush`: latch abs(`src1`), abs(`src2`), `div_signed`, `div_mod`, quotient sign (s1^s2) and remainder sign (s1).
  - Clear the partial remainder and counter, then go to BUSY.
  - If ZERO_FAST=1 and `src2` = 0, go to DONE instead.
- Absolute values apply only when `div_signed`=1; otherwise operands are taken raw.
- BUSY: one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial subtract divisor from the upper WIDTH+1 bits.
  - If non-negative, keep the difference and set the quo LSB.
  - Counter increments; after the step at counter = WIDTH-1, go to DONE.
- DONE:
  - Apply sign fix: negate quo if quotient sign = 1; negate rem if remainder sign = 1.
  - Result is registered on entry to DONE.
  - Hold `div_result` stable until `es_fire`, then go to IDLE.
- `div_stall`, combinational:
  - (IDLE & `es_valid` & `div_req`) | BUSY.
  - Forced to 0 when `flush` = 1.
- `div_busy` = (state == BUSY).
- Latency: request seen in cycle 0 → BUSY in cycles 1..WIDTH → DONE in cycle WIDTH+1.
  - `div_stall` is high in cycles 0..WIDTH, i.e. 33 cycles for WIDTH=32.
  - Divide by zero with ZERO_FAST: DONE in cycle 1, stall high 1 cycle.
- Divide by zero (any signedness):
  - Quotient = all ones (0xFFFFFFFF).
  - Remainder = `src1` unmodified.
  - Bypasses the sign fix.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0. No trap.
- `flush` in any state: next state IDLE, counter cleared, `div_result` unchanged. `flush` wins over a simultaneous request.
- `es_fire` is ignored in IDLE and BUSY; EXE cannot fire while stalled.
- DONE with `es_valid` & `div_req` still asserted:
  - No restart.
  - The same instruction is still in EXE until `es_fire`.
- Back-to-back divides:
  - The next divide reaches EXE at the earliest one cycle after `es_fire`.
  - The FSM is in IDLE by then and accepts it without a bubble.
- `reset` mid-operation: same as reset values; the partial result is discarded.

Test Plan:
- div.wu: `src1`=100, `src2`=7 → `div_stall` high 33 cycles, then `div_result`=14; same operands with mod.wu → 2.
- div.w: `src1`=0xFFFFFF9C (-100), `src2`=7 → 0xFFFFFFF2 (-14); mod.w same operands → 0xFFFFFFFE (-2).
- Divide by zero: `src1`=0x12345678, `src2`=0.
  - ZERO_FAST=1: stall 1 cycle; div → 0xFFFFFFFF, mod → 0x12345678.
  - ZERO_FAST=0: stall 33 cycles, same results.
- Signed overflow: `src1`=0x80000000, `src2`=0xFFFFFFFF, div.w → 0x80000000; mod.w → 0.
- Flush: pulse `flush` at BUSY cycle 10 → next cycle IDLE, `div_busy`=0, `div_stall`=0. A new div.wu 9/3 issued afterwards → 3 after 33 stall cycles.
- Hold and back-to-back:
  - Hold `es_fire` low 5 cycles in DONE → `div_result` stable, no restart.
  - Then `es_fire`=1, followed next cycle by a second div.wu 50/5 → accepted immediately, result 10.
